// File: rtl/imem_loader.sv
// Instruction-memory writer: packs a byte stream into little-endian 32-bit words
// and writes them from address 0 while holding the CPU. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [6:0]        word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE} state_t;
`endif

  state_t              state_q, state_d;
  logic [6:0]          count_q;
  logic [6:0]          idx_q;
  logic [6:0]          idx_nxt;
  logic [1:0]          lane_q;
  logic [DATA_W-9:0]   asm_q;
  logic                accept;

  assign idx_nxt = idx_q + 7'd1;
  assign accept  = byte_valid & byte_ready;

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = COLLECT;
      end
      COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept && lane_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        if (idx_nxt == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = COLLECT;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) state_d = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_hold = busy;

  // Byte capture and word-write register stage: mem_* only move when a word completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      asm_q    <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else begin
      state_q <= state_d;
      mem_we  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q <= (word_count == 7'd0) ? 7'(MAX_WORDS) : word_count;
            idx_q   <= '0;
            lane_q  <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              mem_we   <= 1'b1;
              mem_wd   <= {byte_data, asm_q};
              mem_addr <= ADDR_W'({idx_q, 2'b00});
            end else begin
              asm_q[{lane_q, 3'b000} +: 8] <= byte_data;
            end
          end
        end
        WRITE: idx_q <= idx_nxt;
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xor_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      xor_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == COLLECT && accept) begin
      xor_q <= xor_q ^ byte_data;
    end else if (state_q == CHECK && accept) begin
      err_q <= (byte_data != xor_q);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven single-word loads, hand-written
// corner sequences, and random multi-word loads against an arithmetic packing model.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [6:0]        word_count = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .busy(busy),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic [7:0]        chk_flip = 8'h00;
  logic [7:0]        bq[$];
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write/done monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wd);
      check("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
      check("hold_in_write", {63'd0, cpu_hold}, 64'd1);
    end
    if (done) begin
      done_cnt++;
      check("busy_low_at_done", {62'd0, busy, cpu_hold}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [6:0] wc);
    start = 1'b1;
    word_count = wc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data = b;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      t++;
      if (t > 50) begin
        check("byte_accept_timeout", 64'd0, 64'd1);
        byte_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data = 8'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {63'd0, done_cnt != 0}, 64'd1);
    repeat (3) tick();
  endtask

  // Runs one load of the bytes in bq and checks every write against the packing rule
  task automatic run_load(input logic [6:0] wc, input int maxgap, input bit spurious);
    int n;
    int m;
    logic [7:0]  x;
    logic [31:0] w;
    n = (wc == 7'd0) ? 64 : int'(wc);
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    x = 8'h00;
    pulse_start(wc);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("err_clear_on_start", {63'd0, err}, 64'd0);
`endif
    for (int i = 0; i < 4 * n; i++) begin
      if (spurious && (i % 37) == 5) begin
        start = 1'b1;
        word_count = 7'd3;
      end
      send_byte(bq[i], $urandom_range(0, maxgap));
      start = 1'b0;
      x = x ^ bq[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x ^ chk_flip, $urandom_range(0, maxgap));
`endif
    wait_done();
    check("write_count", 64'(wa_q.size()), 64'(n));
    m = (wa_q.size() < n) ? wa_q.size() : n;
    for (int i = 0; i < m; i++) begin
      w = 32'(bq[4*i]) | (32'(bq[4*i+1]) << 8) | (32'(bq[4*i+2]) << 16) | (32'(bq[4*i+3]) << 24);
      check("write_addr", 64'(wa_q[i]), 64'((i * 4) % (1 << ADDR_W)));
      check("write_data", 64'(wd_q[i]), 64'(w));
    end
    check("done_once", 64'(done_cnt), 64'd1);
    check("idle_after_load", {62'd0, busy, cpu_hold}, 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("err_flag", {63'd0, err}, {63'd0, chk_flip != 8'h00});
`else
    check("err_tied_low", {63'd0, err}, 64'd0);
`endif
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'h13, 8'h00, 8'h10, 8'h00, 32'h0010_0013};
    tbl[1] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 32'hAABB_CCDD};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};
    tbl[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 8'h80, 32'h8000_0000};

    // Reset with toggling inputs
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      start = ~start;
      byte_valid = ~byte_valid;
      @(negedge clk);
      check("reset_outputs", 64'({byte_ready, mem_we, mem_addr, mem_wd, busy, cpu_hold, done, err}), 64'd0);
    end
    start = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single word, latency and done timing by hand
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    pulse_start(7'd1);
    check("hold_while_loading", {63'd0, cpu_hold}, 64'd1);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check("we_after_4th", {63'd0, mem_we}, 64'd1);
    check("first_addr", 64'(mem_addr), 64'h00);
    check("first_wd", 64'(mem_wd), 64'h0010_0013);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h13 ^ 8'h10, 0);
`endif
    @(negedge clk);
    check("done_pulse", {62'd0, done, cpu_hold}, 64'b10);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    tick();

    // Table of single-word loads
    for (int k = 0; k < 5; k++) begin
      bq = {tbl[k].b0, tbl[k].b1, tbl[k].b2, tbl[k].b3};
      run_load(7'd1, 1, 1'b0);
      check("tbl_wd", 64'(wd_q.size() > 0 ? wd_q[0] : 32'hx), 64'(tbl[k].wd));
    end

    // Three words with random stream gaps
    repeat (2) begin
      bq.delete();
      repeat (12) bq.push_back(8'($urandom));
      run_load(7'd3, 3, 1'b0);
    end

    // Full 64-word load with ignored start pulses
    bq.delete();
    repeat (256) bq.push_back(8'($urandom));
    run_load(7'd0, 0, 1'b1);
    check("last_addr", 64'(wa_q.size() == 64 ? wa_q[63] : 8'hx), 64'hFC);

    // Reset in the middle of word 1
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    pulse_start(7'd2);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i), 0);
    rst_n = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'h5A;
    tick();
    tick();
    check("reset_midload_idle", {61'd0, busy, cpu_hold, byte_ready}, 64'd0);
    rst_n = 1'b1;
    byte_valid = 1'b0;
    repeat (8) tick();
    check("reset_midload_writes", 64'(wa_q.size()), 64'd1);
    check("reset_midload_done", 64'(done_cnt), 64'd0);
    bq = {8'h11, 8'h22, 8'h33, 8'h44};
    run_load(7'd1, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    bq = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    chk_flip = 8'h00;
    run_load(7'd1, 0, 1'b0);
    chk_flip = 8'h01;
    run_load(7'd1, 0, 1'b0);
    repeat (4) tick();
    check("err_holds", {63'd0, err}, 64'd1);
    chk_flip = 8'h00;
    bq.delete();
    repeat (8) bq.push_back(8'($urandom));
    run_load(7'd2, 2, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
